piso: RTL and testbench

PISO -- requirements
Module: piso

---
 rtl/piso.sv | 152 +++++++++++++++
 tb/tb_piso.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/piso.sv
// ----------------------------------------------------------------------------
// piso -- parallel-in serial-out shifter, MSB first.
//
// A rising edge with load high captures datain and starts a frame. The first
// frame bit (datain[WIDTH-1]) is on dataout after that same edge, and each
// later edge presents the next lower bit. The frame is WIDTH bits long.
// When PISO_PARITY_EN is defined, one extra bit follows the LSB. That bit is
// the even parity (XOR) of the captured word.
//
// load always wins over shifting: it aborts a running frame and restarts it.
// rst wins over everything and abandons a frame without a done pulse.
//
// Optional feature macro: PISO_PARITY_EN
//
// Parameters
//   WIDTH    parallel word width, 2..32
//
// Ports
//   load     in   capture datain and start a frame at this edge
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   datain   in   parallel word, sampled only on load edges
//   dataout  out  registered serial data
//   valid    out  registered, high while dataout carries a frame bit
//   busy     out  registered, high from capture through the last frame bit
//   done     out  registered, one-cycle pulse with the last frame bit
// ----------------------------------------------------------------------------
module piso #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             load,
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] datain,
    output logic             dataout,
    output logic             valid,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FrameLen = WIDTH + 1;
`else
    localparam int unsigned FrameLen = WIDTH;
`endif
    localparam int unsigned CntW = $clog2(FrameLen + 1);

    typedef logic [CntW-1:0] cnt_t;

    // cnt_q holds the number of frame bits presented so far in this frame.
    localparam cnt_t LastCnt = cnt_t'(FrameLen);
    localparam cnt_t PreLastCnt = cnt_t'(FrameLen - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    cnt_t             cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        dout_d   = 1'b0;
        valid_d  = 1'b0;
        done_d   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif

        if (load) begin
            state_d  = StShift;
            shift_d  = datain;
            dout_d   = datain[WIDTH-1];
            valid_d  = 1'b1;
            cnt_d    = cnt_t'(1);
`ifdef PISO_PARITY_EN
            parity_d = ^datain;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Outputs stay low. The shift register holds its contents.
                end
                StShift: begin
                    if (cnt_q == LastCnt) begin
                        // The last bit was shown in the previous cycle.
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + cnt_t'(1);
                        done_d  = (cnt_q == PreLastCnt);
`ifdef PISO_PARITY_EN
                        if (cnt_q == cnt_t'(WIDTH)) begin
                            dout_d = parity_q;
                        end else begin
                            dout_d  = shift_q[WIDTH-2];
                            shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        end
`else
                        dout_d  = shift_q[WIDTH-2];
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
`endif
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            cnt_q    <= '0;
            dout_q   <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign dataout = dout_q;
    assign valid   = valid_q;
    assign busy    = (state_q == StShift);
    assign done    = done_q;

endmodule

// File: tb/tb_piso.sv
// ----------------------------------------------------------------------------
// tb_piso -- self-checking bench for piso (WIDTH = 8).
// The table holds {rst, load, datain, expected outputs}. Each row is driven on
// the falling edge, and its expected outputs go into a scoreboard queue. After
// the rising edge they are popped and compared with {dataout,valid,busy,done}.
// ----------------------------------------------------------------------------
module tb_piso;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] datain = '0;
    logic         dataout, valid, busy, done;

    piso #(.WIDTH(W)) dut (
        .load   (load),
        .clk    (clk),
        .rst    (rst),
        .datain (datain),
        .dataout(dataout),
        .valid  (valid),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // exp = {dataout, valid, busy, done}
    typedef struct {
        logic         r;
        logic         l;
        logic [W-1:0] d;
        logic [3:0]   exp;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] sb[$];
    int         errors = 0;
    int         checks = 0;
    int         row = 0;

    function automatic void add(input logic r, input logic l, input logic [W-1:0] d,
                                input logic [3:0] exp);
        vec_t v;
        v.r = r;
        v.l = l;
        v.d = d;
        v.exp = exp;
        tbl.push_back(v);
    endfunction

    // Adds the first n rows of a frame carrying w. Non-load rows drive ~w on datain,
    // which the DUT must ignore.
    function automatic void add_bits(input logic [W-1:0] w, input int n);
        logic b;
        for (int k = 0; k < n; k++) begin
            b = (k < W) ? w[W-1-k] : ^w;
            add(1'b0, k == 0, (k == 0) ? w : ~w, {b, 1'b1, 1'b1, k == F - 1});
        end
    endfunction

    function automatic void add_frame(input logic [W-1:0] w);
        add_bits(w, F);
    endfunction

    function automatic void add_idle(input logic [W-1:0] d);
        add(1'b0, 1'b0, d, 4'b0000);
    endfunction

    task automatic step(input logic r, input logic l, input logic [W-1:0] d,
                        input logic [3:0] exp);
        logic [3:0] want;
        @(negedge clk);
        rst = r;
        load = l;
        datain = d;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        checks++;
        if ({dataout, valid, busy, done} !== want) begin
            errors++;
            $display("FAIL step%0d {dout,valid,busy,done} got=%b want=%b", row,
                     {dataout, valid, busy, done}, want);
        end
        row++;
    endtask

    initial begin
        // Two reset edges, then one idle cycle.
        add(1'b1, 1'b0, 8'h00, 4'b0000);
        add(1'b1, 1'b1, 8'hFF, 4'b0000);
        add_idle(8'h55);
        // Basic frame.
        add_frame(8'h0F);
        add_idle(8'hAA);
        // Two frames separated by one idle cycle.
        add_frame(8'hA5);
        add_idle(8'h00);
        add_frame(8'h3C);
        add_idle(8'hFF);
        // A load during the third bit aborts the frame.
        add_bits(8'hFF, 2);
        add_frame(8'h00);
        add_idle(8'h12);
        // Reset during the fourth bit, then a normal frame.
        add_bits(8'h81, 3);
        add(1'b1, 1'b0, 8'h7E, 4'b0000);
        add_idle(8'h7E);
        add_frame(8'h01);
        add_idle(8'h33);
        // load held for four edges.
        add(1'b0, 1'b1, 8'h80, 4'b1110);
        add(1'b0, 1'b1, 8'h80, 4'b1110);
        add(1'b0, 1'b1, 8'h80, 4'b1110);
        add_frame(8'h80);
        add_idle(8'h80);
        // Back-to-back frames: load on the edge right after done.
        add_frame(8'hC6);
        add_frame(8'h39);
        add_idle(8'h00);
        add_idle(8'hFF);

        foreach (tbl[i]) step(tbl[i].r, tbl[i].l, tbl[i].d, tbl[i].exp);

        // Reset beats a simultaneous load in the middle of a frame.
        step(1'b0, 1'b1, 8'hC3, 4'b1110);
        step(1'b0, 1'b0, 8'h00, 4'b1110);
        step(1'b1, 1'b1, 8'hFF, 4'b0000);
        step(1'b0, 1'b0, 8'hFF, 4'b0000);
        // The first load after reset starts a fresh frame.
        begin
            logic [W-1:0] w;
            logic         b;
            w = 8'h5A;
            for (int k = 0; k < F; k++) begin
                b = (k < W) ? w[W-1-k] : ^w;
                step(1'b0, k == 0, (k == 0) ? w : 8'h00, {b, 1'b1, 1'b1, k == F - 1});
            end
        end
        step(1'b0, 1'b0, 8'hA5, 4'b0000);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty size got=%0d want=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
